// File: rtl/alu_pkg.sv
// Shared ALU encodings: operation codes and the sequencer state enum.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDC = 2'b10,
        OP_ACC  = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/addsub_seq_controller_if.sv
// Input-bus / result-path bundle of the serial add/sub controller.
interface addsub_seq_controller_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic [WIDTH-1:0] in;
    logic             store_a;
    logic             start;
    logic [1:0]       op;
    logic             cin;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in, store_a, start, op, cin,
        input  busy, out_valid, out, cout, ovf, zero
    );

    modport slave (
        input  in, store_a, start, op, cin,
        output busy, out_valid, out, cout, ovf, zero
    );

endinterface

// File: rtl/addsub_chunk.sv
// Combinational W-bit adder slice with carry in and carry out.
module addsub_chunk #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum_c,
    output logic         cout_c
);

    logic [W:0] total;

    assign total  = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
    assign sum_c  = total[W-1:0];
    assign cout_c = total[W];

endmodule

// File: rtl/addsub_seq_controller.sv
// Serial ADD/SUB/ADDC/ACC unit: A register, B from the shared bus, CHUNK bits per
// clock, registered result and flags behind a busy/out_valid handshake.
module addsub_seq_controller
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    addsub_seq_controller_if.slave  bus
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;

    if ((WIDTH % CHUNK) != 0 || WIDTH < 2 || CHUNK < 1) begin : g_bad_param
        $error("addsub_seq_controller: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    // Chunk selection: shift the active chunk down to bit 0.
    logic [31:0]      base;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CHUNK-1:0] a_ch, b_ch, sum_ch;
    logic             cout_ch;
    logic [WIDTH-1:0] ins_mask, ins_val, work_nx;

    assign base = 32'(idx_q) * CHUNK;
    assign a_sh = a_q >> base;
    assign b_sh = b_q >> base;
    assign a_ch = a_sh[CHUNK-1:0];
    assign b_ch = b_sh[CHUNK-1:0];

    addsub_chunk #(
        .W (CHUNK)
    ) u_chunk (
        .a      (a_ch),
        .b      (b_ch),
        .cin    (carry_q),
        .sum_c  (sum_ch),
        .cout_c (cout_ch)
    );

    // Working sum with the current chunk merged in.
    assign ins_mask = WIDTH'({CHUNK{1'b1}}) << base;
    assign ins_val  = WIDTH'(sum_ch) << base;
    assign work_nx  = (work_q & ~ins_mask) | ins_val;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        out_d   = out_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.store_a) begin
                    a_d = bus.in;
                end else if (bus.start) begin
                    op_d    = op_e'(bus.op);
                    b_d     = (op_e'(bus.op) == OP_SUB) ? ~bus.in : bus.in;
                    unique case (op_e'(bus.op))
                        OP_SUB:  carry_d = 1'b1;
                        OP_ADDC: carry_d = bus.cin;
                        default: carry_d = 1'b0;
                    endcase
                    idx_d   = '0;
                    work_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                work_d  = work_nx;
                carry_d = cout_ch;
                if (idx_q == IW'(NCH - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    out_d   = work_nx;
                    cout_d  = cout_ch;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (work_nx[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d  = (work_nx == '0);
                    if (op_q == OP_ACC) begin
                        a_d = work_nx;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            out_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = valid_q;
    assign bus.out       = out_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: doc/addsub_seq_controller.md
# addsub_seq_controller

Parametrised, clocked successor to the 8-bit operand-latch adder controller. It holds operand A in a clocked register and accepts operand B from the shared input bus. It computes ADD, SUB, ADD-with-carry or ACCUMULATE serially, CHUNK bits per clock, and presents a registered result with carry, overflow and zero flags behind a busy/valid handshake. The block sits between the board input bus and the display/result path of the ALU.

## Interface
- WIDTH, default 16: operand/result width. Must be a multiple of CHUNK, and WIDTH ≥ 2.
- CHUNK, default 4: bits added per clock. NCH = WIDTH/CHUNK is the number of busy cycles.
- clk  in  1: single clock; all state updates on the rising edge.
- rst_n  in  1: reset, asynchronous and active-low.
- in  in  WIDTH: shared input bus; source of A (on store_a) and of B (on start).
- store_a  in  1: load A from in at the next edge. Honoured in IDLE only.
- start  in  1: launch an operation with B = in and the current op/cin. Honoured in IDLE only.
- op  in  2: 00 ADD, 01 SUB, 10 ADDC, 11 ACC. Sampled with start.
- cin  in  1: carry-in, used by ADDC only. Sampled with start.
- busy  out  1: high while an operation is in progress.
- out_valid  out  1: one-cycle pulse when out and the flags update.
- out  out  WIDTH: last result; held between operations.
- cout  out  1: carry out of the MSB.
- ovf  out  1: two's-complement signed overflow.
- zero  out  1: out == 0.

## Operation
- Reset values: A = 0, out = 0, cout = 0, ovf = 0, zero = 0, busy = 0, out_valid = 0, state IDLE.
- States:
  - IDLE: waits for store_a or start.
  - BUSY: counts chunk index 0..NCH-1. After the edge that processes chunk NCH-1, the block returns to IDLE.
- In IDLE, if store_a and start are both high, store_a wins: A is loaded and start is dropped (no operation).
- At launch, the block latches B, op and the initial carry:
  - ADD: carry 0, B as given.
  - SUB: B is bitwise inverted, carry 1.
  - ADDC: carry = cin.
  - ACC: same as ADD.
- Each BUSY edge adds chunk i of A and B plus the running carry. It writes the chunk-i sum into a working register and stores the carry-out for chunk i+1.
- On the final chunk:
  - out = working sum.
  - cout = MSB carry-out. For SUB, cout = 1 means no borrow.
  - ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' is the possibly inverted B.
  - zero = (sum == 0).
  - out_valid pulses.
  - For ACC only, A is also loaded with the sum.
- start or store_a while busy: ignored, with no side effects. Changes on in/op/cin during BUSY have no effect.
- Asynchronous reset mid-operation aborts the operation: no out_valid, all registers go to their reset values.
- Arithmetic is modulo 2^WIDTH; there is no saturation.

## Timing
- start sampled high in IDLE at edge E0.
- busy = 1 from after E0 until after edge E0+NCH.
- out/flags update and out_valid = 1 for exactly the cycle after E0+NCH; busy = 0 in that same cycle.
- A new start may be sampled at edge E0+NCH+1, giving back-to-back throughput of one result per NCH+1 cycles.
- Latency from start to out_valid is NCH edges.
- store_a takes effect at the sampling edge; the new A is usable by a start on the following edge.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package alu_pkg holds:
  - op encodings: OP_ADD, OP_SUB, OP_ADDC, OP_ACC;
  - state enum: ST_IDLE, ST_BUSY.
- One sub-module, addsub_chunk: combinational CHUNK-bit adder with carry-in and carry-out, instantiated once and muxed by chunk index.
- Chunk counter width is $clog2(NCH), minimum 1.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- Reset, then store_a with in=0x1234, then start ADD with in=0x0FF0 -> busy for 4 cycles, then out=0x2224, cout=0, ovf=0, zero=0, with a single out_valid pulse.
- A=0x0001, start SUB with in=0x0002 -> out=0xFFFF, cout=0, ovf=0. A=0x8000, SUB in=0x0001 -> out=0x7FFF, ovf=1, cout=1.
- A=0x7FFF, ADDC in=0x0000 cin=1 -> out=0x8000, ovf=1. A=0x8000, ADD in=0x8000 -> out=0x0000, cout=1, ovf=1, zero=1.
- A=0, three ACC operations with in=5 -> out 5, 10, 15 in turn; A ends at 15; starts issued on each out_valid cycle are accepted.
- During BUSY, pulse start (in=0xFFFF) and store_a -> result unchanged from the original operation and A unchanged. In IDLE, store_a and start together -> A loaded, no busy, no out_valid.
- Deassert rst_n at chunk index 2 -> busy=0, out=0 immediately, and no out_valid after release.
